// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM state
// encoding, funct3 access-size codes and store-lane helper functions.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size is carried by funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111).
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = 4'b0011 << {a[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data aligner: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension; unknown sizes behave as a word.
  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one bus transaction per aligned load/store,
// pipeline stalled until it completes, extended load data registered for MEM/WB.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] RESET_RDATA = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_ip,
  input  logic                  ex_mem_rd_ip,
  input  logic                  ex_mem_wr_ip,
  input  logic [2:0]            ex_funct3_ip,
  input  logic [31:0]           ex_alu_out_ip,
  input  logic [31:0]           ex_rs2_data_ip,
  output logic [31:0]           alu_out_op,
  output logic [31:0]           mem_rdata_op,
  output logic                  stall_op,
  output logic                  misaligned_op,
  output logic                  dbus_req_op,
  output logic                  dbus_we_op,
  output logic [ADDR_WIDTH-1:0] dbus_addr_op,
  output logic [3:0]            dbus_be_op,
  output logic [31:0]           dbus_wdata_op,
  input  logic                  dbus_gnt_ip,
  input  logic                  dbus_rvalid_ip,
  input  logic [31:0]           dbus_rdata_ip
);

  lsu_state_e            state_q, state_d;
  logic                  access, is_store, mis, start, capture_en;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [2:0]            f3_q;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  // Load wins when both rd and wr are set.
  assign access   = ex_valid_ip & (ex_mem_rd_ip | ex_mem_wr_ip);
  assign is_store = ex_mem_wr_ip & ~ex_mem_rd_ip;
  assign mis      = is_misaligned(ex_funct3_ip[1:0], ex_alu_out_ip[1:0]);
  assign start    = access & ~mis;

  assign alu_out_op   = ex_alu_out_ip;
  assign mem_rdata_op = mem_rdata_q;

  lsu_load_align u_align (
    .rdata_i  (dbus_rdata_ip),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (mem_rdata_d)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ex_* only matter in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (start)          state_d = LSU_REQ;
      LSU_REQ:  if (dbus_gnt_ip)    state_d = we_q ? LSU_DONE : LSU_WAIT;
      LSU_WAIT: if (dbus_rvalid_ip) state_d = LSU_DONE;
      default:                      state_d = LSU_IDLE;
    endcase
  end

  // Outputs decoded from state; stall/misaligned react combinationally in IDLE.
  always_comb begin
    stall_op      = 1'b0;
    misaligned_op = 1'b0;
    dbus_req_op   = 1'b0;
    capture_en    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        misaligned_op = access & mis;
        stall_op      = start;
        capture_en    = start;
      end
      LSU_REQ: begin
        stall_op    = 1'b1;
        dbus_req_op = 1'b1;
      end
      LSU_WAIT: stall_op = 1'b1;
      default:  ;
    endcase
    dbus_we_op    = dbus_req_op & we_q;
    dbus_addr_op  = dbus_req_op ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    dbus_be_op    = dbus_req_op ? be_q : 4'b0000;
    dbus_wdata_op = dbus_req_op ? wdata_q : 32'd0;
  end

  // Request capture, held constant for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      f3_q    <= 3'b000;
    end else if (capture_en) begin
      addr_q  <= ex_alu_out_ip[ADDR_WIDTH-1:0];
      we_q    <= is_store;
      be_q    <= lane_be(ex_funct3_ip[1:0], ex_alu_out_ip[1:0]);
      wdata_q <= is_store ? lane_wdata(ex_funct3_ip[1:0], ex_rs2_data_ip) : 32'd0;
      f3_q    <= ex_funct3_ip;
    end
  end

  // Load result register: updated only by rvalid while waiting on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     mem_rdata_q <= RESET_RDATA;
    else if (state_q == LSU_WAIT && dbus_rvalid_ip) mem_rdata_q <= mem_rdata_d;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed loads/stores with a simple bus
// responder; expected bus requests and retire records are queued at issue.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_ip, ex_mem_rd_ip, ex_mem_wr_ip;
  logic [2:0]  ex_funct3_ip;
  logic [31:0] ex_alu_out_ip, ex_rs2_data_ip;
  logic [31:0] alu_out_op, mem_rdata_op;
  logic        stall_op, misaligned_op;
  logic        dbus_req_op, dbus_we_op;
  logic [31:0] dbus_addr_op;
  logic [3:0]  dbus_be_op;
  logic [31:0] dbus_wdata_op;
  logic        dbus_gnt_ip, dbus_rvalid_ip;
  logic [31:0] dbus_rdata_ip;

  mem_stage_lsu #(.ADDR_WIDTH(32), .RESET_RDATA(32'd0)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_ip(ex_valid_ip), .ex_mem_rd_ip(ex_mem_rd_ip), .ex_mem_wr_ip(ex_mem_wr_ip),
    .ex_funct3_ip(ex_funct3_ip), .ex_alu_out_ip(ex_alu_out_ip), .ex_rs2_data_ip(ex_rs2_data_ip),
    .alu_out_op(alu_out_op), .mem_rdata_op(mem_rdata_op), .stall_op(stall_op),
    .misaligned_op(misaligned_op), .dbus_req_op(dbus_req_op), .dbus_we_op(dbus_we_op),
    .dbus_addr_op(dbus_addr_op), .dbus_be_op(dbus_be_op), .dbus_wdata_op(dbus_wdata_op),
    .dbus_gnt_ip(dbus_gnt_ip), .dbus_rvalid_ip(dbus_rvalid_ip), .dbus_rdata_ip(dbus_rdata_ip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    int          stall;
    logic        mis;
    int          reqc;
    int          grants;
    logic        chk;
    logic [31:0] rdata;
  } ret_t;

  bus_t bus_q[$];
  ret_t ret_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stall_cnt = 0, req_cnt = 0, grant_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic push_ret(input int st, input logic mis, input int rq, input int gr,
                          input logic ck, input logic [31:0] rd);
    ret_t r;
    r.stall = st; r.mis = mis; r.reqc = rq; r.grants = gr; r.chk = ck; r.rdata = rd;
    ret_q.push_back(r);
  endtask

  // Monitor: checks every bus request cycle and every instruction retirement.
  always @(negedge clk) begin
    bus_t b;
    ret_t r;
    if (rst) begin
      stall_cnt = 0; req_cnt = 0; grant_cnt = 0;
    end else begin
      if (dbus_req_op) begin
        req_cnt++;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_req", 32'd1, 32'd0);
        end else begin
          b = bus_q[0];
          chk("bus_we", {31'd0, dbus_we_op}, {31'd0, b.we});
          chk("bus_addr", dbus_addr_op, b.addr);
          if (b.we) begin
            chk("bus_be", {28'd0, dbus_be_op}, {28'd0, b.be});
            chk("bus_wdata", dbus_wdata_op, b.wdata);
          end
          if (dbus_gnt_ip) begin
            void'(bus_q.pop_front());
            grant_cnt++;
          end
        end
      end
      if (ex_valid_ip && stall_op) stall_cnt++;
      if (ex_valid_ip && !stall_op) begin
        if (ret_q.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          r = ret_q.pop_front();
          chk("stall_cycles", stall_cnt, r.stall);
          chk("misaligned", {31'd0, misaligned_op}, {31'd0, r.mis});
          chk("req_cycles", req_cnt, r.reqc);
          chk("grants", grant_cnt, r.grants);
          chk("alu_passthru", alu_out_op, ex_alu_out_ip);
          if (r.chk) chk("mem_rdata", mem_rdata_op, r.rdata);
        end
        stall_cnt = 0; req_cnt = 0; grant_cnt = 0;
      end
    end
  end

  // Issue one instruction and act as bus slave: gnt after gw waiting request
  // cycles, rvalid rvd cycles after a load grant. Called at posedge+1.
  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] rs2,
                    input int gw, input int rvd, input logic [31:0] rdat);
    int req_seen = 0;
    int since = 0;
    bit granted_ld = 0;
    bit done = 0;
    ex_valid_ip = 1'b1; ex_mem_rd_ip = rd; ex_mem_wr_ip = wr;
    ex_funct3_ip = f3; ex_alu_out_ip = addr; ex_rs2_data_ip = rs2;
    for (int c = 0; c < 60 && !done; c++) begin
      dbus_rvalid_ip = 1'b0;
      if (granted_ld) begin
        since++;
        dbus_rvalid_ip = (since == rvd);
      end
      dbus_gnt_ip = dbus_req_op && (req_seen == gw);
      if (dbus_gnt_ip && !dbus_we_op) granted_ld = 1;
      if (dbus_req_op) req_seen++;
      dbus_rdata_ip = rdat;
      @(negedge clk);
      if (!stall_op) done = 1;
      @(posedge clk); #1;
    end
    chk("op_timeout", {31'd0, done}, 32'd1);
    ex_valid_ip = 1'b0; ex_mem_rd_ip = 1'b0; ex_mem_wr_ip = 1'b0;
    dbus_gnt_ip = 1'b0; dbus_rvalid_ip = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ex_valid_ip = 0; ex_mem_rd_ip = 0; ex_mem_wr_ip = 0; ex_funct3_ip = 3'b000;
    ex_alu_out_ip = 32'd0; ex_rs2_data_ip = 32'd0;
    dbus_gnt_ip = 0; dbus_rvalid_ip = 0; dbus_rdata_ip = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, dbus_req_op}, 32'd0);
    chk("rst_addr", dbus_addr_op, 32'd0);
    chk("rst_rdata", mem_rdata_op, 32'd0);
    chk("rst_stall", {31'd0, stall_op}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // LW @0x100
    push_bus(0, 32'h100, 4'hF, 32'h0); push_ret(3, 0, 1, 1, 1, 32'hDEADBEEF);
    op(1, 0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    // LB / LBU @0x103, LH @0x102, LHU @0x100
    push_bus(0, 32'h100, 4'h8, 32'h0); push_ret(3, 0, 1, 1, 1, 32'hFFFFFF80);
    op(1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF0000);
    push_bus(0, 32'h100, 4'h8, 32'h0); push_ret(3, 0, 1, 1, 1, 32'h00000080);
    op(1, 0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF0000);
    push_bus(0, 32'h100, 4'hC, 32'h0); push_ret(3, 0, 1, 1, 1, 32'hFFFF80FF);
    op(1, 0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80FF0000);
    push_bus(0, 32'h100, 4'h3, 32'h0); push_ret(3, 0, 1, 1, 1, 32'h0000F00D);
    op(1, 0, 3'b101, 32'h100, 32'h0, 0, 1, 32'h1234F00D);
    // Stores leave mem_rdata untouched
    push_bus(1, 32'h200, 4'h2, 32'hA5A5A5A5); push_ret(2, 0, 1, 1, 1, 32'h0000F00D);
    op(0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 1, 32'h0);
    push_bus(1, 32'h200, 4'hC, 32'hBEEFBEEF); push_ret(2, 0, 1, 1, 1, 32'h0000F00D);
    op(0, 1, 3'b001, 32'h202, 32'h0000BEEF, 0, 1, 32'h0);
    push_bus(1, 32'h204, 4'hF, 32'h11223344); push_ret(2, 0, 1, 1, 1, 32'h0000F00D);
    op(0, 1, 3'b010, 32'h204, 32'h11223344, 0, 1, 32'h0);
    // Misaligned: no request, no stall
    push_ret(0, 1, 0, 0, 1, 32'h0000F00D);
    op(1, 0, 3'b010, 32'h102, 32'h0, 0, 1, 32'h0);
    push_ret(0, 1, 0, 0, 1, 32'h0000F00D);
    op(0, 1, 3'b001, 32'h101, 32'h0, 0, 1, 32'h0);
    // rd and wr both set -> load
    push_bus(0, 32'h100, 4'h2, 32'h0); push_ret(3, 0, 1, 1, 1, 32'h0000007F);
    op(1, 1, 3'b000, 32'h101, 32'hFFFFFFFF, 0, 1, 32'h00007F00);
    // funct3 011 behaves as word
    push_bus(0, 32'h108, 4'hF, 32'h0); push_ret(3, 0, 1, 1, 1, 32'hCAFEF00D);
    op(1, 0, 3'b011, 32'h108, 32'h0, 0, 1, 32'hCAFEF00D);
    // gnt withheld 5 cycles on a store
    push_bus(1, 32'h300, 4'hF, 32'h55AA55AA); push_ret(7, 0, 6, 1, 1, 32'hCAFEF00D);
    op(0, 1, 3'b010, 32'h300, 32'h55AA55AA, 5, 1, 32'h0);
    // rvalid late by 3 cycles
    push_bus(0, 32'h100, 4'h1, 32'h0); push_ret(5, 0, 1, 1, 1, 32'hFFFFFFFE);
    op(1, 0, 3'b000, 32'h100, 32'h0, 0, 3, 32'h000000FE);
    // Non-memory op, then stray gnt/rvalid in IDLE, then another non-memory op
    push_ret(0, 0, 0, 0, 1, 32'hFFFFFFFE);
    op(0, 0, 3'b010, 32'h00000123, 32'h0, 0, 1, 32'h0);
    dbus_rvalid_ip = 1'b1; dbus_gnt_ip = 1'b1; dbus_rdata_ip = 32'h11111111;
    @(posedge clk); #1;
    dbus_rvalid_ip = 1'b0; dbus_gnt_ip = 1'b0;
    push_ret(0, 0, 0, 0, 1, 32'hFFFFFFFE);
    op(0, 0, 3'b000, 32'h00000456, 32'h0, 0, 1, 32'h0);

    // Reset while waiting for read data
    push_bus(0, 32'h400, 4'hF, 32'h0);
    ex_valid_ip = 1; ex_mem_rd_ip = 1; ex_mem_wr_ip = 0; ex_funct3_ip = 3'b010;
    ex_alu_out_ip = 32'h400;
    @(posedge clk); #1;
    dbus_gnt_ip = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_ip = 1'b0;
    rst = 1'b1; ex_valid_ip = 0; ex_mem_rd_ip = 0;
    #1;
    chk("midrst_req", {31'd0, dbus_req_op}, 32'd0);
    chk("midrst_stall", {31'd0, stall_op}, 32'd0);
    chk("midrst_rdata", mem_rdata_op, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dbus_rvalid_ip = 1'b1; dbus_rdata_ip = 32'h12345678;
    @(posedge clk); #1;
    dbus_rvalid_ip = 1'b0;
    @(negedge clk);
    chk("late_rvalid_rdata", mem_rdata_op, 32'd0);
    chk("late_rvalid_req", {31'd0, dbus_req_op}, 32'd0);
    @(posedge clk); #1;
    // Recovery after reset
    push_bus(0, 32'h104, 4'hF, 32'h0); push_ret(3, 0, 1, 1, 1, 32'hA1B2C3D4);
    op(1, 0, 3'b010, 32'h104, 32'h0, 0, 1, 32'hA1B2C3D4);

    repeat (2) @(posedge clk);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("ret_q_drained", ret_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
